// File: rtl/corr_mac_seq_pkg.sv
// Shared constants, FSM encodings and the term-count helper for the
// sequential MAC correlator.
package corr_pkg;

  localparam int DEPTH_LOG2 = 3;
  localparam int HALF_W     = 3;
  localparam int ACC_W      = 9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Number of products to accumulate, N = 2**len_sel.
  function automatic logic [DEPTH_LOG2:0] term_count(input logic [1:0] len_sel);
    term_count = {{DEPTH_LOG2{1'b0}}, 1'b1} << len_sel;
  endfunction

  // Index of the final term; N = 2**DEPTH_LOG2 wraps to all ones.
  function automatic logic [DEPTH_LOG2-1:0] last_index(input logic [1:0] len_sel);
    logic [DEPTH_LOG2:0] n;
    n          = term_count(len_sel);
    last_index = n[DEPTH_LOG2-1:0] - {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/corr_mac_seq_if.sv
// Write/control/result bundle between the correlator and its driver.
interface corr_mac_seq_if import corr_pkg::*; ();

  logic                    wr_en;
  logic [DEPTH_LOG2-1:0]   wr_addr;
  logic [2*HALF_W-1:0]     wr_data;
  logic [1:0]              len_sel;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [ACC_W-1:0]        result;
  logic                    wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, len_sel, start,
    input  busy, done, result, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len_sel, start,
    output busy, done, result, wr_err
  );

endinterface

// File: rtl/corr_mac_seq_sample_buf.sv
// Operand-pair register file: synchronous write and clear, asynchronous read.
module corr_sample_buf import corr_pkg::*; #(
  parameter int ADDR_W = DEPTH_LOG2,
  parameter int DATA_W = 2*HALF_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage update: clear all entries, else write one entry.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        mem[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end else begin
      mem[wr_addr] <= mem[wr_addr];
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/corr_mac_seq.sv
// Sequential multiply-accumulate correlator: sums N = 2**len_sel operand
// products from the sample buffer, one per cycle, into a full-width result.
module corr_mac_seq import corr_pkg::*; (
  input  logic           clk,
  input  logic           rst_n,
  corr_mac_seq_if.slave  bus
);

  logic [1:0]            state;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] last_idx;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      result_hold;
  logic                  run_busy;
  logic                  done_pulse;
  logic                  err_pulse;

  logic [2*HALF_W-1:0]   rd_data;
  logic [HALF_W-1:0]     op_a;
  logic [HALF_W-1:0]     op_b;
  logic [ACC_W-1:0]      prod;
  logic [ACC_W-1:0]      sum;
  logic                  buf_we;

  corr_sample_buf #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (2*HALF_W)
  ) u_buf (
    .clk     (clk),
    .clr_n   (rst_n),
    .wr_en   (buf_we),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  // Product of the current entry and the running sum including it.
  always_comb begin
    op_a   = rd_data[HALF_W-1:0];
    op_b   = rd_data[2*HALF_W-1:HALF_W];
    prod   = ACC_W'(op_a) * ACC_W'(op_b);
    sum    = acc + prod;
    // Operands are frozen while a run is in progress.
    buf_we = bus.wr_en && (state != ST_ACC);
  end

  // Run control, accumulation and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= {DEPTH_LOG2{1'b0}};
      last_idx    <= {DEPTH_LOG2{1'b0}};
      acc         <= {ACC_W{1'b0}};
      result_hold <= {ACC_W{1'b0}};
      run_busy    <= 1'b0;
      done_pulse  <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      err_pulse  <= bus.wr_en && (state == ST_ACC);
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            last_idx <= last_index(bus.len_sel);
            idx      <= {DEPTH_LOG2{1'b0}};
            acc      <= {ACC_W{1'b0}};
            run_busy <= 1'b1;
            state    <= ST_ACC;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACC: begin
          acc <= sum;
          idx <= idx + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
          if (idx == last_idx) begin
            result_hold <= sum;
            run_busy    <= 1'b0;
            done_pulse  <= 1'b1;
            state       <= ST_FIN;
          end else begin
            state <= ST_ACC;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          run_busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = run_busy;
  assign bus.done   = done_pulse;
  assign bus.result = result_hold;
  assign bus.wr_err = err_pulse;

endmodule

// File: tb/tb_corr_mac_seq.sv
// Directed self-checking bench for corr_mac_seq.
module tb_corr_mac_seq;
  import corr_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  corr_mac_seq_if bus ();

  corr_mac_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [5:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic fill(input logic [5:0] data);
    for (int i = 0; i < 8; i++) wr(3'(i), data);
  endtask

  // Pulse start; len_sel is scrambled afterwards to show it is latched.
  task automatic start_run(input logic [1:0] len);
    bus.start   = 1'b1;
    bus.len_sel = len;
    tick();
    bus.start   = 1'b0;
    bus.len_sel = ~len;
  endtask

  task automatic wait_done(output int cyc, output int bcnt, output bit to);
    cyc  = 0;
    bcnt = 0;
    to   = 1'b0;
    while (bus.done !== 1'b1) begin
      if (cyc >= 20) begin
        to = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) bcnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    int  c;
    int  b;
    bit  t;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.wr_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.wr_err});
    end
    checks++;
    if (bus.result !== 9'd0) begin
      errors++;
      $display("FAIL reset_result: got %0d expected 0", bus.result);
    end
    rst_n = 1'b1;
    tick();
    start_run(2'd3);
    wait_done(c, b, t);
    checks++;
    if (t || bus.result !== 9'd0) begin
      errors++;
      $display("FAIL reset_buf_clear: got %0d (timeout %0d) expected 0", bus.result, t);
    end
    tick();
  endtask

  task automatic test_basic;
    int  c;
    int  b;
    bit  t;
    fill(6'b001001);
    start_run(2'd3);
    wait_done(c, b, t);
    checks++;
    if (t || c != 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles (timeout %0d) expected 8", c, t);
    end
    checks++;
    if (b != 8) begin
      errors++;
      $display("FAIL basic_busy: got %0d busy cycles expected 8", b);
    end
    checks++;
    if (bus.result !== 9'd8) begin
      errors++;
      $display("FAIL basic_result: got %0d expected 8", bus.result);
    end
    tick();
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic_done_pulse: got done,busy=%b expected 00", {bus.done, bus.busy});
    end
    checks++;
    if (bus.result !== 9'd8) begin
      errors++;
      $display("FAIL basic_result_hold: got %0d expected 8", bus.result);
    end
  endtask

  task automatic test_max;
    int  c;
    int  b;
    bit  t;
    fill(6'b111111);
    start_run(2'd3);
    wait_done(c, b, t);
    checks++;
    if (t || bus.result !== 9'd392) begin
      errors++;
      $display("FAIL max_n8: got %0d (timeout %0d) expected 392", bus.result, t);
    end
    tick();
    start_run(2'd0);
    wait_done(c, b, t);
    checks++;
    if (t || c != 1) begin
      errors++;
      $display("FAIL max_n1_latency: got %0d cycles (timeout %0d) expected 1", c, t);
    end
    checks++;
    if (bus.result !== 9'd49) begin
      errors++;
      $display("FAIL max_n1: got %0d expected 49", bus.result);
    end
    tick();
  endtask

  task automatic test_pattern;
    int         c;
    int         b;
    bit         t;
    logic [2:0] hi;
    logic [2:0] lo;
    for (int i = 0; i < 8; i++) begin
      hi = 3'(i);
      lo = 3'(i + 1);
      wr(3'(i), {hi, lo});
    end
    start_run(2'd2);
    wait_done(c, b, t);
    checks++;
    if (t || c != 4 || bus.result !== 9'd20) begin
      errors++;
      $display("FAIL pattern_n4: got %0d in %0d cycles (timeout %0d) expected 20 in 4", bus.result, c, t);
    end
    tick();
    start_run(2'd1);
    wait_done(c, b, t);
    checks++;
    if (t || c != 2 || bus.result !== 9'd2) begin
      errors++;
      $display("FAIL pattern_n2: got %0d in %0d cycles (timeout %0d) expected 2 in 2", bus.result, c, t);
    end
    tick();
  endtask

  task automatic test_write_during_acc;
    int  c;
    int  b;
    bit  t;
    int  dcnt;
    start_run(2'd2);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = 6'b111111;
    bus.start   = 1'b1;
    bus.len_sel = 2'd0;
    tick();
    bus.wr_en   = 1'b0;
    bus.start   = 1'b0;
    checks++;
    if (bus.wr_err !== 1'b1) begin
      errors++;
      $display("FAIL acc_wr_err: got %b expected 1", bus.wr_err);
    end
    tick();
    checks++;
    if (bus.wr_err !== 1'b0) begin
      errors++;
      $display("FAIL acc_wr_err_pulse: got %b expected 0", bus.wr_err);
    end
    wait_done(c, b, t);
    checks++;
    if (t || c != 2 || bus.result !== 9'd20) begin
      errors++;
      $display("FAIL acc_result: got %0d after %0d cycles (timeout %0d) expected 20 after 2", bus.result, c, t);
    end
    tick();
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) dcnt++;
      tick();
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL acc_single_done: got %0d extra done pulses expected 0", dcnt);
    end
    start_run(2'd0);
    wait_done(c, b, t);
    checks++;
    if (t || bus.result !== 9'd0) begin
      errors++;
      $display("FAIL acc_buf_unchanged: got %0d (timeout %0d) expected 0", bus.result, t);
    end
    tick();
  endtask

  task automatic test_reset_mid_acc;
    int  c;
    int  b;
    bit  t;
    int  dcnt;
    fill(6'b111111);
    start_run(2'd3);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.result !== 9'd0) begin
      errors++;
      $display("FAIL abort_state: got busy,done=%b result=%0d expected 00 and 0", {bus.busy, bus.done}, bus.result);
    end
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1) dcnt++;
      tick();
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", dcnt);
    end
    start_run(2'd3);
    wait_done(c, b, t);
    checks++;
    if (t || c != 8 || bus.result !== 9'd0) begin
      errors++;
      $display("FAIL abort_buf_clear: got %0d in %0d cycles (timeout %0d) expected 0 in 8", bus.result, c, t);
    end
    tick();
  endtask

  task automatic test_write_start_same;
    int  c;
    int  b;
    bit  t;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = 6'b010011;
    bus.start   = 1'b1;
    bus.len_sel = 2'd0;
    tick();
    bus.wr_en   = 1'b0;
    bus.start   = 1'b0;
    bus.len_sel = 2'd3;
    wait_done(c, b, t);
    checks++;
    if (t || c != 1 || bus.result !== 9'd6) begin
      errors++;
      $display("FAIL same_cycle_wr_start: got %0d in %0d cycles (timeout %0d) expected 6 in 1", bus.result, c, t);
    end
    tick();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 3'd0;
    bus.wr_data = 6'd0;
    bus.len_sel = 2'd0;
    bus.start   = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_max();
    test_pattern();
    test_write_during_acc();
    test_reset_mid_acc();
    test_write_start_same();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
